dffre_shift_bank: RTL and testbench

//  Parametrised successor of the single-bit enable/reset flop: WIDTH-bit x DEPTH-stage register

---
 rtl/dffre_shift_bank.sv | 81 ++++++++
 tb/tb_dffre_shift_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dffre_shift_bank.sv
// WIDTH x DEPTH register bank with enable, synchronous active-low reset and
// hold/shift/load/rotate modes, plus a saturating count of valid stages.
module dffre_shift_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_Enable,
  input  logic [1:0]                     i_Mode,
  input  logic [WIDTH-1:0]               i_D,
  input  logic [WIDTH*DEPTH-1:0]         i_Load,
  output logic [WIDTH-1:0]               o_Q,
  output logic [WIDTH*DEPTH-1:0]         o_Taps,
  output logic [$clog2(DEPTH+1)-1:0]     o_Fill,
  output logic                           o_Full
);

  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_t;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;
  logic             full_q;

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) stage_d[k] = stage_q[k];
    fill_d = fill_q;
    if (i_Enable) begin
      // An undefined mode falls through to default and behaves as HOLD.
      case (mode_t'(i_Mode))
        MODE_SHIFT: begin
          for (int unsigned k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
          stage_d[0] = i_D;
          if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
        end
        MODE_LOAD: begin
          for (int unsigned k = 0; k < DEPTH; k++) stage_d[k] = i_Load[k*WIDTH +: WIDTH];
          fill_d = FILL_MAX;
        end
        MODE_ROTATE: begin
          for (int unsigned k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
          stage_d[0] = stage_q[DEPTH-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= RESET_VALUE;
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
      fill_q <= fill_d;
      full_q <= (fill_d == FILL_MAX);
    end
  end

  always_comb begin
    o_Taps = '0;
    for (int unsigned k = 0; k < DEPTH; k++) o_Taps[k*WIDTH +: WIDTH] = stage_q[k];
  end

  assign o_Q    = stage_q[DEPTH-1];
  assign o_Fill = fill_q;
  assign o_Full = full_q;

endmodule

// File: tb/tb_dffre_shift_bank.sv
// Scoreboard bench for dffre_shift_bank (WIDTH=8, DEPTH=4): the driver queues
// the expected state per edge, a negedge monitor pops and compares.
module tb_dffre_shift_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  d;
  logic [31:0] load;
  logic [7:0]  q;
  logic [31:0] taps;
  logic [2:0]  fill;
  logic        full;

  typedef struct {
    logic [31:0] taps;
    logic [7:0]  q;
    logic [2:0]  fill;
    logic        full;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  logic [7:0] m [4];
  int         mfill;

  always #5 clk = ~clk;

  dffre_shift_bank #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) dut (
    .i_Clk   (clk),
    .i_Reset (rst_n),
    .i_Enable(en),
    .i_Mode  (mode),
    .i_D     (d),
    .i_Load  (load),
    .o_Q     (q),
    .o_Taps  (taps),
    .o_Fill  (fill),
    .o_Full  (full)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_compared++;
      if (taps !== e.taps || q !== e.q || fill !== e.fill || full !== e.full) begin
        n_failed++;
        $display("FAIL %s: got taps=%h q=%h fill=%0d full=%b, required taps=%h q=%h fill=%0d full=%b",
                 e.name, taps, q, fill, full, e.taps, e.q, e.fill, e.full);
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [1:0] md, input logic [7:0] dv,
                      input logic [31:0] ld, input logic [31:0] xt, input logic [2:0] xf,
                      input logic xfull, input string nm);
    exp_t x;
    rst_n = r; en = e; mode = md; d = dv; load = ld;
    x.taps = xt; x.q = xt[31:24]; x.fill = xf; x.full = xfull; x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] mt;
    logic [7:0]  t;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; d = '0; load = '0;

    // 1: reset dominates an enabled SHIFT
    step(0, 1, 2'b01, 8'hFF, 32'h0, 32'h0, 0, 0, "reset1");
    step(0, 1, 2'b01, 8'hFF, 32'h0, 32'h0, 0, 0, "reset2");

    // 2: shift fill-up and saturation
    step(1, 1, 2'b01, 8'h11, 32'h0, 32'h00000011, 1, 0, "shift1");
    step(1, 1, 2'b01, 8'h22, 32'h0, 32'h00001122, 2, 0, "shift2");
    step(1, 1, 2'b01, 8'h33, 32'h0, 32'h00112233, 3, 0, "shift3");
    step(1, 1, 2'b01, 8'h44, 32'h0, 32'h11223344, 4, 1, "shift4");
    step(1, 1, 2'b01, 8'h55, 32'h0, 32'h22334455, 4, 1, "shift5_sat");

    // 3: enable low freezes everything
    for (int i = 0; i < 10; i++)
      step(1, 0, 2'(i), 8'(i * 37 + 1), 32'hDEADBEEF, 32'h22334455, 4, 1, "disabled_hold");

    // 4: load and rotate
    step(0, 1, 2'b01, 8'h00, 32'h0, 32'h0, 0, 0, "reset_pre_load");
    step(1, 1, 2'b10, 8'h00, 32'hA1B2C3D4, 32'hA1B2C3D4, 4, 1, "load");
    step(1, 1, 2'b11, 8'h00, 32'h0, 32'hB2C3D4A1, 4, 1, "rotate1");
    step(1, 1, 2'b11, 8'h00, 32'h0, 32'hC3D4A1B2, 4, 1, "rotate2");
    step(1, 1, 2'b11, 8'h00, 32'h0, 32'hD4A1B2C3, 4, 1, "rotate3");
    step(1, 1, 2'b11, 8'h00, 32'h0, 32'hA1B2C3D4, 4, 1, "rotate4");
    step(1, 1, 2'b00, 8'h99, 32'h0, 32'hA1B2C3D4, 4, 1, "hold_mode");

    // 5: reset mid shift burst
    step(0, 1, 2'b00, 8'h00, 32'h0, 32'h0, 0, 0, "reset_pre_burst");
    step(1, 1, 2'b01, 8'h01, 32'h0, 32'h00000001, 1, 0, "burst1");
    step(1, 1, 2'b01, 8'h02, 32'h0, 32'h00000102, 2, 0, "burst2");
    step(0, 1, 2'b01, 8'h77, 32'h0, 32'h0, 0, 0, "reset_mid_burst");

    // 6: random traffic against a stage-array reference model
    for (int k = 0; k < 4; k++) m[k] = '0;
    mfill = 0;
    for (int i = 0; i < 1500; i++) begin
      logic       r, e;
      logic [1:0] md;
      logic [7:0] dv;
      logic [31:0] ld;
      r  = ($urandom_range(0, 19) != 0);
      e  = ($urandom_range(0, 3) != 0);
      md = 2'($urandom_range(0, 3));
      dv = 8'($urandom);
      ld = $urandom;
      if (!r) begin
        for (int k = 0; k < 4; k++) m[k] = '0;
        mfill = 0;
      end else if (e) begin
        case (md)
          2'b01: begin
            m[3] = m[2]; m[2] = m[1]; m[1] = m[0]; m[0] = dv;
            if (mfill < 4) mfill++;
          end
          2'b10: begin
            m[0] = ld[7:0]; m[1] = ld[15:8]; m[2] = ld[23:16]; m[3] = ld[31:24];
            mfill = 4;
          end
          2'b11: begin
            t = m[3]; m[3] = m[2]; m[2] = m[1]; m[1] = m[0]; m[0] = t;
          end
          default: ;
        endcase
      end
      mt = {m[3], m[2], m[1], m[0]};
      step(r, e, md, dv, ld, mt, 3'(mfill), (mfill == 4), "random");
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_failed++;
      $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
